// File: rtl/gcn_transform_pkg.sv
// Shared types and width helpers for the GCN feature/weight transformation
// scheduler and its column counter.
package gcn_transform_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    COMPUTE,
    DRAIN,
    EMIT,
    DONE
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/transformation_scheduler_weight_col_counter.sv
// Weight-column counter: clears on request, steps on incr, saturates at N-1.
module weight_col_counter
  import gcn_transform_pkg::*;
#(
  parameter int  N = 3,
  localparam int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         incr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && count != LAST) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/transformation_scheduler.sv
// Sequences weight-column loads and per-row feature MACs for one
// feature x weight matrix product, emitting one result per (row, column).
module transformation_scheduler
  import gcn_transform_pkg::*;
#(
  parameter int  FEATURE_ROWS = 4,
  parameter int  FEATURE_COLS = 3,
  parameter int  WEIGHT_COLS  = 3,
  localparam int ROW_W = idx_w(FEATURE_ROWS),
  localparam int K_W   = idx_w(FEATURE_COLS),
  localparam int COL_W = idx_w(WEIGHT_COLS),
  localparam int FA_W  = addr_w(FEATURE_ROWS * FEATURE_COLS),
  localparam int WA_W  = addr_w(FEATURE_COLS * WEIGHT_COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             weight_rd_en,
  output logic [WA_W-1:0]  weight_rd_addr,
  output logic             wbuf_wr_en,
  output logic [K_W-1:0]   wbuf_idx,
  output logic             feat_rd_en,
  output logic [FA_W-1:0]  feat_rd_addr,
  output logic             mac_en,
  output logic [K_W-1:0]   mac_k,
  output logic             mac_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] weight_count
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(FEATURE_COLS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WEIGHT_COLS - 1);

  state_t           state, state_n;
  logic [ROW_W-1:0] row;
  logic [K_W-1:0]   k;
  logic [COL_W-1:0] col;

  logic launch, accept;
  logic k_last, row_last, col_last;
  logic col_clear, col_incr;

  assign launch   = (state == IDLE) && start;
  assign accept   = (state == EMIT) && out_ready;
  assign k_last   = (k == K_LAST);
  assign row_last = (row == ROW_LAST);
  assign col_last = (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = LOAD_W;
      LOAD_W:  if (k_last) state_n = COMPUTE;
      COMPUTE: if (k_last) state_n = DRAIN;
      DRAIN:   state_n = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (!row_last)      state_n = COMPUTE;
          else if (!col_last) state_n = LOAD_W;
          else                state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      k   <= '0;
      row <= '0;
    end else begin
      if (launch) begin
        k <= '0;
      end else if (state == LOAD_W || state == COMPUTE) begin
        k <= k_last ? '0 : k + 1'b1;
      end
      if (launch) begin
        row <= '0;
      end else if (accept) begin
        row <= row_last ? '0 : row + 1'b1;
      end
    end
  end

  // Column only advances once every row has consumed the loaded weights.
  assign col_clear = launch || (state == DONE);
  assign col_incr  = accept && row_last && !col_last;

  weight_col_counter #(
    .N(WEIGHT_COLS)
  ) u_col (
    .clk  (clk),
    .reset(reset),
    .clear(col_clear),
    .incr (col_incr),
    .count(col)
  );

  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign out_valid    = (state == EMIT);
  assign out_row      = row;
  assign weight_count = col;
  assign weight_rd_en = (state == LOAD_W);
  assign feat_rd_en   = (state == COMPUTE);

  assign weight_rd_addr = weight_rd_en
    ? WA_W'(k) * WA_W'(WEIGHT_COLS) + WA_W'(col) : '0;
  assign feat_rd_addr = feat_rd_en
    ? FA_W'(row) * FA_W'(FEATURE_COLS) + FA_W'(k) : '0;

  // Memory returns data one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wbuf_wr_en <= 1'b0;
      wbuf_idx   <= '0;
      mac_en     <= 1'b0;
      mac_k      <= '0;
    end else begin
      wbuf_wr_en <= weight_rd_en;
      wbuf_idx   <= weight_rd_en ? k : '0;
      mac_en     <= feat_rd_en;
      mac_k      <= feat_rd_en ? k : '0;
    end
  end

  assign mac_clear = mac_en && (mac_k == '0);

endmodule

// File: tb/tb_transformation_scheduler.sv
// Directed, table-driven bench for transformation_scheduler at 2x3x3.
module tb_transformation_scheduler;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       wre;
    logic [3:0] waddr;
    logic       wbe;
    logic [1:0] widx;
    logic       fre;
    logic [2:0] faddr;
    logic       me;
    logic [1:0] mk;
    logic       mc;
    logic       ov;
    logic       row;
    logic [1:0] wc;
  } out_t;

  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;

  logic       clk = 0;
  logic       reset;
  logic       start;
  logic       out_ready;
  logic       busy, done, weight_rd_en, wbuf_wr_en;
  logic       feat_rd_en, mac_en, mac_clear, out_valid;
  logic [3:0] weight_rd_addr;
  logic [1:0] wbuf_idx, mac_k, weight_count;
  logic [2:0] feat_rd_addr;
  logic [0:0] out_row;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  out_t tr[0:47];
  out_t zero = '0;

  transformation_scheduler #(
    .FEATURE_ROWS(2),
    .FEATURE_COLS(3),
    .WEIGHT_COLS (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .weight_rd_en  (weight_rd_en),
    .weight_rd_addr(weight_rd_addr),
    .wbuf_wr_en    (wbuf_wr_en),
    .wbuf_idx      (wbuf_idx),
    .feat_rd_en    (feat_rd_en),
    .feat_rd_addr  (feat_rd_addr),
    .mac_en        (mac_en),
    .mac_k         (mac_k),
    .mac_clear     (mac_clear),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_row       (out_row),
    .weight_count  (weight_count)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t s;
    s.busy  = busy;
    s.done  = done;
    s.wre   = weight_rd_en;
    s.waddr = weight_rd_addr;
    s.wbe   = wbuf_wr_en;
    s.widx  = wbuf_idx;
    s.fre   = feat_rd_en;
    s.faddr = feat_rd_addr;
    s.me    = mac_en;
    s.mk    = mac_k;
    s.mc    = mac_clear;
    s.ov    = out_valid;
    s.row   = out_row[0];
    s.wc    = weight_count;
    return s;
  endfunction

  function automatic out_t ev(
    bit b, bit d, bit wre, int wa, bit wbe, int wi,
    bit fre, int fa, bit me, int mk, bit mc,
    bit ov, bit row, int wc);
    out_t s;
    s.busy  = b;
    s.done  = d;
    s.wre   = wre;
    s.waddr = 4'(wa);
    s.wbe   = wbe;
    s.widx  = 2'(wi);
    s.fre   = fre;
    s.faddr = 3'(fa);
    s.me    = me;
    s.mk    = 2'(mk);
    s.mc    = mc;
    s.ov    = ov;
    s.row   = row;
    s.wc    = 2'(wc);
    return s;
  endfunction

  task automatic chk(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic add(input int c, input out_t e);
    vec_t v;
    v.cyc = c;
    v.exp = e;
    vecs.push_back(v);
  endtask

  // Full run with out_ready=1; cycle 0 is the cycle start is presented.
  task automatic trace_run(input bit hold_start);
    int hs;
    int first_done;
    hs = 0;
    first_done = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      tr[c] = sample();
      if (out_valid && out_ready) hs++;
      if (done && first_done < 0) first_done = c;
      start = hold_start ? 1'b1 : (c == 0);
    end
    start = 1'b0;
    foreach (vecs[i])
      chk($sformatf("run%0d cyc%0d", hold_start, vecs[i].cyc),
          tr[vecs[i].cyc], vecs[i].exp);
    chk_int("done_cycle", first_done, 40);
    chk_int("handshakes", hs, 6);
    if (hold_start) begin
      chk("restart_cyc42", tr[42], ev(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
      for (int c = 1; c <= 40; c++)
        if (!tr[c].busy) begin
          chk_int($sformatf("busy_cyc%0d", c), 0, 1);
          break;
        end
    end
  endtask

  task automatic settle_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit seen;
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;

    add(0,  ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
    add(1,  ev(1,0,1,0,0,0,0,0,0,0,0,0,0,0));
    add(2,  ev(1,0,1,3,1,0,0,0,0,0,0,0,0,0));
    add(3,  ev(1,0,1,6,1,1,0,0,0,0,0,0,0,0));
    add(4,  ev(1,0,0,0,1,2,1,0,0,0,0,0,0,0));
    add(5,  ev(1,0,0,0,0,0,1,1,1,0,1,0,0,0));
    add(6,  ev(1,0,0,0,0,0,1,2,1,1,0,0,0,0));
    add(7,  ev(1,0,0,0,0,0,0,0,1,2,0,0,0,0));
    add(8,  ev(1,0,0,0,0,0,0,0,0,0,0,1,0,0));
    add(9,  ev(1,0,0,0,0,0,1,3,0,0,0,0,1,0));
    add(13, ev(1,0,0,0,0,0,0,0,0,0,0,1,1,0));
    add(14, ev(1,0,1,1,0,0,0,0,0,0,0,0,0,1));
    add(27, ev(1,0,1,2,0,0,0,0,0,0,0,0,0,2));
    add(39, ev(1,0,0,0,0,0,0,0,0,0,0,1,1,2));
    add(40, ev(1,1,0,0,0,0,0,0,0,0,0,0,0,2));
    add(41, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0));

    repeat (3) @(negedge clk);
    chk("reset_state", sample(), zero);
    reset = 1'b1;

    trace_run(1'b0);

    // Back-pressure on the first EMIT.
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      seen = out_valid;
    end
    if (!seen) chk_int("emit_timeout", 0, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", c), sample(),
          ev(1,0,0,0,0,0,0,0,0,0,0,1,0,0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", sample(), ev(1,0,0,0,0,0,1,3,0,0,0,0,1,0));
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) chk_int("done_timeout", 0, 1);

    // Reset in the middle of the second COMPUTE.
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 10) chk("pre_reset", sample(),
                       ev(1,0,0,0,0,0,1,4,1,0,1,0,1,0));
      if (c == 11) chk("post_reset", sample(), zero);
      start = (c == 0);
      if (c == 10) reset = 1'b0;
    end
    reset = 1'b1;
    start = 1'b0;

    trace_run(1'b0);
    trace_run(1'b1);
    settle_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/transformation_scheduler.md
TRANSFORMATION_SCHEDULER -- requirements
Module: transformation_scheduler

Interface
REQ-001 SHALL have parameter FEATURE_ROWS, default 4: rows of the feature matrix.
REQ-002 SHALL have parameter FEATURE_COLS, default 3: inner dimension K, equal to the number of weight rows.
REQ-003 SHALL have parameter WEIGHT_COLS, default 3: columns of the weight matrix.
REQ-004 SHALL have these ports, clock and reset first (widths: ROW_W/K_W/COL_W = max(1,$clog2(N)); FA_W/WA_W = $clog2 of the matrix size):
- clk  in  1  clock, single domain.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin one full transformation.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- weight_rd_en  out  1  weight memory read strobe.
- weight_rd_addr  out  WA_W  read address k*WEIGHT_COLS+col.
- wbuf_wr_en  out  1  write the returned weight word into buffer slot wbuf_idx.
- wbuf_idx  out  K_W  weight buffer slot.
- feat_rd_en  out  1  feature memory read strobe.
- feat_rd_addr  out  FA_W  read address row*FEATURE_COLS+k.
- mac_en  out  1  accumulate the returned feature word times wbuf[mac_k].
- mac_k  out  K_W  buffer index used with mac_en.
- mac_clear  out  1  restart accumulation (valid only with mac_en).
- out_valid  out  1  accumulator result ready.
- out_ready  in  1  consumer accepts the result.
- out_row  out  ROW_W  row of the current result.
- weight_count  out  COL_W  current weight column.

Function
REQ-005 SHALL be an FSM with states IDLE, LOAD_W, COMPUTE, DRAIN, EMIT, DONE.
REQ-006 In IDLE, start=1 SHALL clear all counters and go to LOAD_W; start SHALL be ignored in every other state.
REQ-007 LOAD_W SHALL last FEATURE_COLS cycles, with weight_rd_en=1 and k stepping 0..K-1, then go to COMPUTE.
REQ-008 wbuf_wr_en/wbuf_idx SHALL be weight_rd_en/k delayed one cycle (one-cycle memory read latency).
REQ-009 COMPUTE SHALL last FEATURE_COLS cycles, with feat_rd_en=1 and k stepping 0..K-1, then go to DRAIN.
REQ-010 mac_en/mac_k SHALL be feat_rd_en/k delayed one cycle; mac_clear SHALL be high exactly when mac_en=1 and mac_k=0.
REQ-011 DRAIN SHALL last one cycle, covering the final mac_en, then go to EMIT.
REQ-012 EMIT SHALL hold out_valid=1, with out_row and weight_count stable, until out_ready=1; out_ready outside EMIT SHALL be ignored.
REQ-013 On EMIT acceptance: if row < FEATURE_ROWS-1, SHALL increment row and go to COMPUTE; otherwise SHALL clear row.
REQ-014 On EMIT acceptance with the last row: if weight_count < WEIGHT_COLS-1, SHALL increment weight_count and go to LOAD_W; otherwise SHALL go to DONE.
REQ-015 DONE SHALL assert done for one cycle, then return to IDLE; weight_count SHALL be cleared on that exit.
REQ-016 Counters SHALL never exceed N-1; wrap SHALL happen only under REQ-013/014/015; address arithmetic SHALL be unsigned and sized to the matrix.
REQ-017 Each output cycle: at most one of weight_rd_en and feat_rd_en high; all strobes low in IDLE, EMIT and DONE (except delayed mac_en/wbuf_wr_en per REQ-008/010).

Reset
REQ-018 reset=0 at a clock edge SHALL force IDLE, all counters 0, and every output 0, including mid-operation.
REQ-019 Pipelined delayed strobes SHALL be cleared by reset, so no mac_en or wbuf_wr_en appears in the cycle after reset.

Structure
REQ-020 The FSM state enum and width helper functions SHALL live in the shared package gcn_transform_pkg.
REQ-021 The column counter SHALL be one instantiated sub-module, weight_col_counter (clear and incr inputs, count output); row and k counters SHALL stay inline.

Verification
REQ-022 Parameters 2/3/3, out_ready=1, start pulsed at cycle 0 -> LOAD_W at cycle 1, done=1 at cycle 40, exactly 6 out_valid handshakes.
REQ-023 First LOAD_W -> weight_rd_addr 0,3,6 on cycles 1-3; wbuf_wr_en with wbuf_idx 0,1,2 on cycles 2-4.
REQ-024 First COMPUTE (cycles 4-6) -> feat_rd_addr 0,1,2; mac_en on cycles 5-7; mac_clear only on cycle 5; out_valid at cycle 8.
REQ-025 out_ready=0 for 5 cycles during the first EMIT -> out_valid, out_row=0, weight_count=0 held, no strobes; advance on the first cycle out_ready=1.
REQ-026 reset=0 during the second COMPUTE -> next cycle state IDLE and all outputs 0; a later start gives the full REQ-022 sequence.
REQ-027 start held high through a whole run -> ignored while busy; a new run begins from IDLE after done.
